// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the MEM-stage store buffer
package store_buffer_pkg;

  localparam int SB_DEPTH    = 4;
  localparam int WORD_ADDR_W = 30;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [31:0]            data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - youngest-match lookup over the buffered stores
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]       valid,
  input  sb_entry_t              entries [DEPTH],
  input  logic [PTR_W-1:0]       tail,
  input  logic [WORD_ADDR_W-1:0] lookup_addr,
  output logic                   hit,
  output logic [PTR_W-1:0]       hit_idx
);

  logic [PTR_W-1:0] idx;

  // Walk from tail-1 back toward the oldest slot; the first match is the youngest store.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail - PTR_W'(k);
      if (!hit && valid[idx] && (entries[idx].word_addr == lookup_addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with load forwarding and drain arbitration
// Optional macro STORE_BUF_FWD_EN: forward load hits from the buffer instead of stalling them.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        empty_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] off;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;

  logic req_rd, req_wr, full;
  logic load_hit, load_miss, fwd, load_stall;
  logic do_enq, do_drain;
  logic unused_bits;

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - head;
      valid[i] = ({1'b0, off} < count);
    end
  end

  store_buffer_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .valid       (valid),
    .entries     (entries),
    .tail        (tail),
    .lookup_addr (addr_i[31:2]),
    .hit         (hit),
    .hit_idx     (hit_idx)
  );

  // Requests are masked during reset so every output sits at its idle value.
  assign req_rd    = MemRead_i & rst_i;
  assign req_wr    = MemWrite_i & rst_i;
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign load_hit  = req_rd & hit;
  assign load_miss = req_rd & ~hit;

`ifdef STORE_BUF_FWD_EN
  assign fwd         = load_hit;
  assign load_stall  = 1'b0;
  assign unused_bits = ^addr_i[1:0];
`else
  assign fwd         = 1'b0;
  assign load_stall  = load_hit;
  assign unused_bits = ^{addr_i[1:0], hit_idx};
`endif

  assign stall_o  = load_stall | (req_wr & full);
  assign do_enq   = req_wr & ~full;
  assign do_drain = (count != '0) & ~load_miss;
  assign empty_o  = (count == '0);

  always_comb begin
    data_o = '0;
    if (fwd)            data_o = entries[hit_idx].data;
    else if (load_miss) data_o = mem_data_i;
  end

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    if (load_miss) begin
      mem_read_o = 1'b1;
      mem_addr_o = {addr_i[31:2], 2'b00};
    end else if (do_drain) begin
      mem_write_o = 1'b1;
      mem_addr_o  = {entries[head].word_addr, 2'b00};
      mem_data_o  = entries[head].data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (do_enq) begin
        entries[tail] <= '{word_addr: addr_i[31:2], data: data_i};
        tail          <= tail + 1'b1;
      end
      if (do_drain) head <= head + 1'b1;
      count <= count + (PTR_W+1)'(do_enq) - (PTR_W+1)'(do_drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench: directed table, reset corner, randomized model compare
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemWrite_i, MemRead_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        stall_o, empty_o, mem_write_o, mem_read_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
    .empty_o(empty_o), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_data_i = dmem[mem_addr_o[9:2]];
  always @(posedge clk_i) if (mem_write_o) dmem[mem_addr_o[9:2]] <= mem_data_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we, re;
    logic [31:0] addr, wdata;
    logic        stall, mw, mr;
    logic [31:0] maddr, mdata, rdata;
    logic        empty, chk_rdata;
  } vec_t;

  function automatic vec_t mk(logic we, logic re, logic [31:0] addr, logic [31:0] wdata,
                              logic stall, logic mw, logic mr, logic [31:0] maddr,
                              logic [31:0] mdata, logic [31:0] rdata, logic empty, logic chk_rdata);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.stall = stall; v.mw = mw; v.mr = mr; v.maddr = maddr; v.mdata = mdata;
    v.rdata = rdata; v.empty = empty; v.chk_rdata = chk_rdata;
    return v;
  endfunction

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
  } st_t;

  vec_t vecs [14];
  st_t  q [$];

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    rst_i = 1'b0; MemWrite_i = 0; MemRead_i = 0; addr_i = '0; data_i = '0;

    // Outputs held idle during reset even with a request present
    #12;
    MemRead_i = 1'b1; addr_i = 32'h40;
    #1;
    chk("rst stall", stall_o, 0);
    chk("rst empty", empty_o, 1);
    chk("rst mem_write", mem_write_o, 0);
    chk("rst mem_read", mem_read_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst mem_data", mem_data_o, 0);
    chk("rst data_o", data_o, 0);
    MemRead_i = 1'b0; addr_i = '0;
    @(negedge clk_i) rst_i = 1'b1;

    //            we re addr      wdata  stall mw mr maddr     mdata  rdata  empty chk
    vecs[0]  = mk(1, 0, 32'h040, 32'h11, 0,    0, 0, 32'h000,  32'h0, 32'h0,  1, 1);
`ifdef STORE_BUF_FWD_EN
    vecs[1]  = mk(0, 1, 32'h040, 32'h0,  0,    1, 0, 32'h040,  32'h11, 32'h11, 0, 1);
`else
    vecs[1]  = mk(0, 1, 32'h040, 32'h0,  1,    1, 0, 32'h040,  32'h11, 32'h0,  0, 0);
`endif
    vecs[2]  = mk(0, 1, 32'h040, 32'h0,  0,    0, 1, 32'h040,  32'h0, 32'h11, 1, 1);
    vecs[3]  = mk(1, 0, 32'h080, 32'hA,  0,    0, 0, 32'h000,  32'h0, 32'h0,  1, 1);
    vecs[4]  = mk(1, 0, 32'h080, 32'hB,  0,    1, 0, 32'h080,  32'hA, 32'h0,  0, 1);
`ifdef STORE_BUF_FWD_EN
    vecs[5]  = mk(0, 1, 32'h082, 32'h0,  0,    1, 0, 32'h080,  32'hB, 32'hB,  0, 1);
`else
    vecs[5]  = mk(0, 1, 32'h082, 32'h0,  1,    1, 0, 32'h080,  32'hB, 32'h0,  0, 0);
`endif
    vecs[6]  = mk(0, 1, 32'h082, 32'h0,  0,    0, 1, 32'h080,  32'h0, 32'hB,  1, 1);
    vecs[7]  = mk(1, 0, 32'h100, 32'h1,  0,    0, 0, 32'h000,  32'h0, 32'h0,  1, 1);
    vecs[8]  = mk(0, 1, 32'h104, 32'h0,  0,    0, 1, 32'h104,  32'h0, 32'h0,  0, 1);
    vecs[9]  = mk(1, 0, 32'h104, 32'h2,  0,    1, 0, 32'h100,  32'h1, 32'h0,  0, 1);
    vecs[10] = mk(0, 1, 32'h100, 32'h0,  0,    0, 1, 32'h100,  32'h0, 32'h1,  0, 1);
    vecs[11] = mk(1, 0, 32'h100, 32'h3,  0,    1, 0, 32'h104,  32'h2, 32'h0,  0, 1);
    vecs[12] = mk(0, 0, 32'h000, 32'h0,  0,    1, 0, 32'h100,  32'h3, 32'h0,  0, 1);
    vecs[13] = mk(0, 0, 32'h000, 32'h0,  0,    0, 0, 32'h000,  32'h0, 32'h0,  1, 1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      MemWrite_i = vecs[i].we; MemRead_i = vecs[i].re;
      addr_i = vecs[i].addr; data_i = vecs[i].wdata;
      #2;
      chk($sformatf("vec%0d stall", i), stall_o, vecs[i].stall);
      chk($sformatf("vec%0d mem_write", i), mem_write_o, vecs[i].mw);
      chk($sformatf("vec%0d mem_read", i), mem_read_o, vecs[i].mr);
      chk($sformatf("vec%0d mem_addr", i), mem_addr_o, vecs[i].maddr);
      chk($sformatf("vec%0d mem_data", i), mem_data_o, vecs[i].mdata);
      chk($sformatf("vec%0d empty", i), empty_o, vecs[i].empty);
      if (vecs[i].chk_rdata) chk($sformatf("vec%0d data_o", i), data_o, vecs[i].rdata);
    end
    #4;
    chk("mem 0x040", dmem[8'h10], 32'h11);
    chk("mem 0x080", dmem[8'h20], 32'hB);
    chk("mem 0x100", dmem[8'h40], 32'h3);
    chk("mem 0x104", dmem[8'h41], 32'h2);

    // Reset asserted while a buffered store is draining
    @(negedge clk_i);
    MemWrite_i = 1'b1; MemRead_i = 1'b0; addr_i = 32'h200; data_i = 32'h55;
    @(negedge clk_i);
    MemWrite_i = 1'b0; addr_i = '0; data_i = '0;
    #2;
    chk("drain before reset", mem_write_o, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("reset drops mem_write", mem_write_o, 0);
    chk("reset empties", empty_o, 1);
    chk("reset mem_addr", mem_addr_o, 0);
    @(negedge clk_i) rst_i = 1'b1;
    #2;
    chk("discarded store not drained", mem_write_o, 0);
    chk("mem 0x200 untouched", dmem[8'h80], 32'h0);

    // Randomized traffic against a queue-based model over words 0x300..0x31C
    q.delete();
    for (int cyc = 0; cyc < 406; cyc++) begin
      logic        we, re, hit, miss, drain, stall;
      logic [31:0] a, d, e_maddr, e_mdata, e_rdata;
      int          op, yi;
      op = (cyc < 400) ? int'($urandom_range(0, 2)) : 0;
      we = (op == 1);
      re = (op == 2);
      a  = 32'h300 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      d  = $urandom;
      hit = 1'b0; yi = 0;
      for (int k = 0; k < q.size(); k++)
        if (q[k].w == a[31:2]) begin hit = 1'b1; yi = k; end
      hit = hit & re;
      miss  = re & ~hit;
      drain = (q.size() > 0) & ~miss;
`ifdef STORE_BUF_FWD_EN
      stall = we & (q.size() == DEPTH);
`else
      stall = (we & (q.size() == DEPTH)) | hit;
`endif
      e_maddr = miss ? {a[31:2], 2'b00} : (drain ? {q[0].w, 2'b00} : 32'h0);
      e_mdata = drain ? q[0].d : 32'h0;
      e_rdata = !re ? 32'h0 : (miss ? ref_mem[a[9:2]] : (hit ? q[yi].d : 32'h0));

      @(negedge clk_i);
      MemWrite_i = we; MemRead_i = re; addr_i = a; data_i = d;
      #2;
      chk($sformatf("rnd%0d stall", cyc), stall_o, stall);
      chk($sformatf("rnd%0d mem_write", cyc), mem_write_o, drain);
      chk($sformatf("rnd%0d mem_read", cyc), mem_read_o, miss);
      chk($sformatf("rnd%0d mem_addr", cyc), mem_addr_o, e_maddr);
      chk($sformatf("rnd%0d mem_data", cyc), mem_data_o, e_mdata);
      chk($sformatf("rnd%0d empty", cyc), empty_o, q.size() == 0);
      if (!stall) chk($sformatf("rnd%0d data_o", cyc), data_o, e_rdata);

      @(posedge clk_i);
      if (drain) begin
        ref_mem[q[0].w[7:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (we && !stall) q.push_back('{w: a[31:2], d: d});
    end
    #4;
    for (int i = 8'hC0; i < 8'hC8; i++)
      chk($sformatf("rnd mem word %0d", i), dmem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
